// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
// Purely declarative: no logic, no latency, no flow control.
package apb_arb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int SLV_IDX_W = 4;

    function automatic logic [(1 << SLV_IDX_W)-1:0] onehot(input logic [SLV_IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first set request after ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the parent decides when a grant is consumed.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant_oh,
    output logic [PTR_W-1:0] grant_idx
);

    logic found;

    // First pass covers the indices above ptr, second pass wraps to 0..ptr.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j > int'(ptr))) begin
                found       = 1'b1;
                grant_oh[j] = 1'b1;
                grant_idx   = PTR_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j]) begin
                found       = 1'b1;
                grant_oh[j] = 1'b1;
                grant_idx   = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB bus between REQ_NUM requesters with round-robin grant.
// Latency: accept c0, SETUP c1, ACCESS c2.., rsp_valid one cycle after pready.
// Backpressure: req_ready pulses only in IDLE; other requests wait, no queueing.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int REQ_NUM     = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int PADDR_WIDTH = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int PSLV_NUM    = 5,
    parameter int TIMEOUT     = 16
) (
    input  logic                              hclk,
    input  logic                              hresetn,
    input  logic [REQ_NUM-1:0]                req_valid,
    output logic [REQ_NUM-1:0]                req_ready,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0]     req_addr,
    input  logic [REQ_NUM-1:0]                req_write,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]     req_wdata,
    input  logic [REQ_NUM*DATA_WIDTH/8-1:0]   req_wstrb,
    output logic [REQ_NUM-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic                              rsp_err,
    output logic [PADDR_WIDTH-1:0]            paddr,
    output logic [PSLV_NUM-1:0]               psel,
    output logic                              penable,
    output logic                              pwrite,
    output logic [DATA_WIDTH-1:0]             pwdata,
    output logic [DATA_WIDTH/8-1:0]           pstrb,
    input  logic [PSLV_NUM-1:0]               pready_i,
    input  logic [PSLV_NUM*DATA_WIDTH-1:0]    prdata_i
);

    localparam int PTR_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int SIDX_W = (PSLV_NUM > 1) ? $clog2(PSLV_NUM) : 1;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d, gnt_q, gnt_d;
    logic [SIDX_W-1:0]       sidx_q, sidx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PSLV_NUM-1:0]     psel_q, psel_d;
    logic                    penable_q, penable_d, pwrite_q, pwrite_d;
    logic [PADDR_WIDTH-1:0]  paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [STRB_W-1:0]       pstrb_q, pstrb_d;
    logic [REQ_NUM-1:0]      rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [REQ_NUM-1:0]      arb_oh, gnt_oh;
    logic [PTR_W-1:0]        arb_idx;
    logic [ADDR_WIDTH-1:0]   cand_addr;
    logic [SLV_IDX_W-1:0]    cand_sidx;
    logic [(1 << SLV_IDX_W)-1:0] slv_oh;
    logic                    unused_bits;

    rr_arbiter #(.N(REQ_NUM), .PTR_W(PTR_W)) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx)
    );

    assign cand_addr   = req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign cand_sidx   = cand_addr[PADDR_WIDTH +: SLV_IDX_W];
    assign slv_oh      = onehot(cand_sidx);
    assign unused_bits = ^{cand_addr, slv_oh};

    always_comb begin
        gnt_oh         = '0;
        gnt_oh[gnt_q]  = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        sidx_d      = sidx_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    // Gated so nothing is accepted while reset is held.
                    req_ready = arb_oh & {REQ_NUM{hresetn}};
                    gnt_d     = arb_idx;
                    if (int'(cand_sidx) < PSLV_NUM) begin
                        sidx_d   = SIDX_W'(cand_sidx);
                        psel_d   = slv_oh[PSLV_NUM-1:0];
                        paddr_d  = cand_addr[PADDR_WIDTH-1:0];
                        pwrite_d = req_write[arb_idx];
                        pwdata_d = req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                        pstrb_d  = req_write[arb_idx] ? req_wstrb[arb_idx*STRB_W +: STRB_W] : '0;
                        state_d  = SETUP;
                    end else begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready_i[sidx_q]) begin
                    rsp_rdata_d = pwrite_q ? '0 : prdata_i[sidx_q*DATA_WIDTH +: DATA_WIDTH];
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = gnt_oh;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    if (cnt_q != CNT_W'(TIMEOUT)) cnt_d = cnt_q + CNT_W'(1);
                    if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = gnt_oh;
                        psel_d      = '0;
                        penable_d   = 1'b0;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                // Decode errors arrive with rsp_valid still low and spend one extra cycle here.
                if (|rsp_valid_q) begin
                    rsp_valid_d = '0;
                    ptr_d       = gnt_q;
                    state_d     = IDLE;
                end else begin
                    rsp_valid_d = gnt_oh;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_W'(REQ_NUM - 1);
            gnt_q       <= '0;
            sidx_q      <= '0;
            cnt_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            sidx_q      <= sidx_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: two requesters, five slaves, TIMEOUT=16.
module tb_apb_master_arbiter;

    localparam int RN = 2, AW = 32, PW = 16, DW = 32, SN = 5, TO = 16;

    logic               hclk = 1'b0;
    logic               hresetn = 1'b0;
    logic [RN-1:0]      req_valid, req_ready, req_write, rsp_valid;
    logic [RN*AW-1:0]   req_addr;
    logic [RN*DW-1:0]   req_wdata;
    logic [RN*DW/8-1:0] req_wstrb;
    logic [DW-1:0]      rsp_rdata, pwdata;
    logic               rsp_err, penable, pwrite;
    logic [PW-1:0]      paddr;
    logic [SN-1:0]      psel, pready_i;
    logic [DW/8-1:0]    pstrb;
    logic [SN*DW-1:0]   prdata_i;

    int n_cmp = 0;
    int n_mis = 0;
    int cnt[2];

    always #5 hclk = ~hclk;

    apb_master_arbiter #(
        .REQ_NUM(RN), .ADDR_WIDTH(AW), .PADDR_WIDTH(PW),
        .DATA_WIDTH(DW), .PSLV_NUM(SN), .TIMEOUT(TO)
    ) dut (
        .hclk(hclk), .hresetn(hresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pready_i(pready_i), .prdata_i(prdata_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge hclk);
    endtask

    task automatic set_req(input int r, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        req_addr[r*AW +: AW]    = addr;
        req_write[r]            = wr;
        req_wdata[r*DW +: DW]   = wdata;
        req_wstrb[r*4 +: 4]     = wstrb;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        pready_i  = '0;
        prdata_i[0*DW +: DW] = 32'h0000_0A00;
        prdata_i[1*DW +: DW] = 32'h1111_0001;
        prdata_i[2*DW +: DW] = 32'hA5A5_0001;
        prdata_i[3*DW +: DW] = 32'h3333_0003;
        prdata_i[4*DW +: DW] = 32'h4444_4444;

        // Reset: everything 0, no accept even with requests pending.
        req_valid = 2'b11;
        cyc(); cyc(); #1;
        check("rst_ready", req_ready, 2'b00);
        check("rst_psel", psel, 5'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_paddr", paddr, 16'h0);
        req_valid = 2'b00;
        cyc(); hresetn = 1'b1;

        // Single read, zero-wait slave 2; nonzero wstrb must not reach pstrb.
        cyc();
        set_req(0, 32'h4002_0010, 1'b0, 32'hFFFF_FFFF, 4'hF);
        req_valid = 2'b01; pready_i = 5'b00100;
        #1 check("rd_ready", req_ready, 2'b01);
        cyc(); req_valid = 2'b00;
        check("rd_c1_psel", psel, 5'b00100);
        check("rd_c1_paddr", paddr, 16'h0010);
        check("rd_c1_penable", penable, 1'b0);
        check("rd_c1_pstrb", pstrb, 4'h0);
        check("rd_c1_pwrite", pwrite, 1'b0);
        cyc();
        check("rd_c2_penable", penable, 1'b1);
        check("rd_c2_rsp_valid", rsp_valid, 2'b00);
        cyc();
        check("rd_c3_rsp_valid", rsp_valid, 2'b01);
        check("rd_c3_rdata", rsp_rdata, 32'hA5A5_0001);
        check("rd_c3_err", rsp_err, 1'b0);
        check("rd_c3_psel", psel, 5'b0);
        cyc();
        check("rd_c4_rsp_valid", rsp_valid, 2'b00);

        // Wait states: slave 0 holds pready low 5 ACCESS cycles; other slaves ready.
        set_req(1, 32'h4000_0044, 1'b1, 32'hDEAD_BEEF, 4'b0101);
        req_valid = 2'b10; pready_i = 5'b11110;
        #1 check("ws_ready", req_ready, 2'b10);
        cyc(); req_valid = 2'b00;
        check("ws_c1_apb", {psel, penable, paddr, pwrite, pwdata, pstrb},
              {5'b00001, 1'b0, 16'h0044, 1'b1, 32'hDEAD_BEEF, 4'b0101});
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("ws_access_apb", {psel, penable, paddr, pwrite, pwdata, pstrb},
                  {5'b00001, 1'b1, 16'h0044, 1'b1, 32'hDEAD_BEEF, 4'b0101});
            check("ws_access_rsp", rsp_valid, 2'b00);
        end
        pready_i = 5'b11111;
        cyc();
        check("ws_rsp_valid", rsp_valid, 2'b10);
        check("ws_rsp_err", rsp_err, 1'b0);
        check("ws_rsp_rdata", rsp_rdata, 32'h0);
        check("ws_rsp_psel", psel, 5'b0);

        // Contention: both requesters hold valid for 3 writes each.
        cyc();
        cnt[0] = 0; cnt[1] = 0;
        set_req(0, 32'h4001_0000, 1'b1, 32'h1000_0000, 4'hF);
        set_req(1, 32'h4003_0020, 1'b1, 32'h2000_0000, 4'h3);
        req_valid = 2'b11;
        #1;
        for (int it = 0; it < 6; it++) begin
            int g, waited;
            g = it % 2;
            waited = 0;
            while (req_ready == 2'b00 && waited < 12) begin
                cyc(); #1;
                waited++;
            end
            check("cont_grant", req_ready, (g == 0) ? 2'b01 : 2'b10);
            cyc();
            check("cont_psel", psel, (g == 0) ? 5'b00010 : 5'b01000);
            check("cont_paddr", paddr, (g == 0) ? 32'h0000 + 4*cnt[0] : 32'h0020 + 4*cnt[1]);
            check("cont_pwdata", pwdata, (g == 0) ? 32'h1000_0000 + cnt[0] : 32'h2000_0000 + cnt[1]);
            check("cont_pstrb", pstrb, (g == 0) ? 4'hF : 4'h3);
            check("cont_pwrite", pwrite, 1'b1);
            cnt[g]++;
            if (cnt[g] == 3) req_valid[g] = 1'b0;
            else if (g == 0) set_req(0, 32'h4001_0000 + 4*cnt[0], 1'b1, 32'h1000_0000 + cnt[0], 4'hF);
            else             set_req(1, 32'h4003_0020 + 4*cnt[1], 1'b1, 32'h2000_0000 + cnt[1], 4'h3);
            cyc(); cyc();
            check("cont_rsp", rsp_valid, (g == 0) ? 2'b01 : 2'b10);
        end

        // Timeout: slave 4 never ready; others ready but must be ignored.
        cyc();
        set_req(0, 32'h4004_0008, 1'b0, 32'h0, 4'h0);
        req_valid = 2'b01; pready_i = 5'b01111;
        #1 check("to_ready", req_ready, 2'b01);
        cyc(); req_valid = 2'b00;
        check("to_c1_psel", psel, 5'b10000);
        for (int k = 2; k <= 17; k++) begin
            cyc();
            check("to_access_rsp", rsp_valid, 2'b00);
            if (k == 17) check("to_c17_apb", {psel, penable}, {5'b10000, 1'b1});
        end
        cyc();
        check("to_rsp_valid", rsp_valid, 2'b01);
        check("to_rsp_err", rsp_err, 1'b1);
        check("to_rsp_rdata", rsp_rdata, 32'h0);
        check("to_psel_drop", {psel, penable}, {5'b0, 1'b0});

        // Next request after a timeout completes normally.
        cyc();
        set_req(1, 32'h4003_0004, 1'b0, 32'h0, 4'h0);
        req_valid = 2'b10; pready_i = 5'b11111;
        #1 check("post_to_ready", req_ready, 2'b10);
        cyc(); req_valid = 2'b00;
        check("post_to_psel", psel, 5'b01000);
        cyc(); cyc();
        check("post_to_rsp", rsp_valid, 2'b10);
        check("post_to_rdata", rsp_rdata, 32'h3333_0003);
        check("post_to_err", rsp_err, 1'b0);

        // Decode error: slave index 7 does not exist.
        cyc();
        set_req(0, 32'h4007_0000, 1'b0, 32'h0, 4'h0);
        req_valid = 2'b01;
        #1 check("dec_ready", req_ready, 2'b01);
        cyc(); req_valid = 2'b00;
        check("dec_c1_psel", psel, 5'b0);
        check("dec_c1_rsp", rsp_valid, 2'b00);
        cyc();
        check("dec_c2_rsp", rsp_valid, 2'b01);
        check("dec_c2_err", rsp_err, 1'b1);
        check("dec_c2_psel", psel, 5'b0);
        cyc();
        check("dec_c3_rsp", rsp_valid, 2'b00);

        // Reset asserted during ACCESS, then simultaneous requests.
        set_req(0, 32'h4001_0010, 1'b0, 32'h0, 4'h0);
        req_valid = 2'b01; pready_i = 5'b11101;
        #1 check("ra_ready", req_ready, 2'b01);
        cyc(); req_valid = 2'b00;
        cyc();
        check("ra_access", {psel, penable}, {5'b00010, 1'b1});
        #2 hresetn = 1'b0;
        #1 check("ra_async_clear", {psel, penable, paddr, pwrite, pstrb, rsp_valid, rsp_err},
                 {5'b0, 1'b0, 16'h0, 1'b0, 4'h0, 2'b00, 1'b0});
        cyc(); cyc();
        hresetn = 1'b1;
        pready_i = 5'b11111;
        cyc();
        set_req(0, 32'h4002_0000, 1'b0, 32'h0, 4'h0);
        set_req(1, 32'h4003_0000, 1'b0, 32'h0, 4'h0);
        req_valid = 2'b11;
        #1 check("ra_first_grant", req_ready, 2'b01);
        cyc(); req_valid = 2'b10;
        check("ra_psel", psel, 5'b00100);
        cyc(); cyc();
        check("ra_rsp", rsp_valid, 2'b01);
        check("ra_rdata", rsp_rdata, 32'hA5A5_0001);
        req_valid = 2'b00;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
